// File: rtl/action_pkg.sv
// Shared constants for the action/header join: action word layout,
// decoded action record and default header-vector field offsets.
package action_pkg;

  localparam int unsigned ACTION_WIDTH = 128;

  // Enable bits in the low byte of the action word
  localparam int unsigned ACT_SET_DMAC = 0;
  localparam int unsigned ACT_SET_SMAC = 1;
  localparam int unsigned ACT_SET_VLAN = 2;
  localparam int unsigned ACT_DEC_TTL  = 3;
  localparam int unsigned ACT_DROP     = 4;

  // Field payload positions in the action word
  localparam int unsigned ACT_DMAC_LSB = 16;
  localparam int unsigned ACT_SMAC_LSB = 64;
  localparam int unsigned ACT_VLAN_LSB = 112;

  // Default header-vector layout
  localparam int unsigned DEF_AVST_DATA_WIDTH = 600;
  localparam int unsigned DEF_DMAC_OFFSET     = 0;
  localparam int unsigned DEF_SMAC_OFFSET     = 48;
  localparam int unsigned DEF_VLAN_OFFSET     = 112;
  localparam int unsigned DEF_TTL_OFFSET      = 208;
  localparam int unsigned DEF_CSUM_OFFSET     = 224;

  typedef struct packed {
    logic [15:0] vlan;
    logic [47:0] smac;
    logic [47:0] dmac;
    logic        set_dmac;
    logic        set_smac;
    logic        set_vlan;
    logic        dec_ttl;
    logic        drop;
  } action_t;

endpackage

// File: rtl/ipv4_csum_adjust.sv
// Incremental IPv4 header checksum update for a single 16-bit word change:
// csum_out = ~(~csum_in + ~old16 + new16) in ones'-complement arithmetic.
module ipv4_csum_adjust (
  input  logic [15:0] old16,
  input  logic [15:0] new16,
  input  logic [15:0] csum_in,
  output logic [15:0] csum_out
);

  logic [16:0] sum1;
  logic [15:0] fold1;
  logic [16:0] sum2;
  logic [15:0] fold2;

  // Two end-around-carry additions; each fold cannot overflow again
  always_comb begin
    sum1     = {1'b0, ~csum_in} + {1'b0, ~old16};
    fold1    = sum1[15:0] + {15'd0, sum1[16]};
    sum2     = {1'b0, fold1} + {1'b0, new16};
    fold2    = sum2[15:0] + {15'd0, sum2[16]};
    csum_out = ~fold2;
  end

endmodule

// File: rtl/action_set_join.sv
// Joins header vectors with match-table action words, applies field edits
// (DMAC/SMAC/VLAN set, TTL decrement, drop) and emits the edited header
// through a two-stage registered pipeline with valid/ready handshakes.
// Optional: `define ACTION_SET_JOIN_CSUM_EN to incrementally fix the IPv4
// checksum on TTL decrement.
module action_set_join
  import action_pkg::*;
#(
  parameter int unsigned AVST_DATA_WIDTH = DEF_AVST_DATA_WIDTH,
  parameter int unsigned DMAC_OFFSET     = DEF_DMAC_OFFSET,
  parameter int unsigned SMAC_OFFSET     = DEF_SMAC_OFFSET,
  parameter int unsigned VLAN_OFFSET     = DEF_VLAN_OFFSET,
  parameter int unsigned TTL_OFFSET      = DEF_TTL_OFFSET,
  parameter int unsigned CSUM_OFFSET     = DEF_CSUM_OFFSET
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AVST_DATA_WIDTH-1:0] s_hdr_data,
  input  logic                       s_hdr_valid,
  output logic                       s_hdr_ready,
  input  logic [ACTION_WIDTH-1:0]    s_act_data,
  input  logic                       s_act_valid,
  output logic                       s_act_ready,
  output logic [AVST_DATA_WIDTH-1:0] m_hdr_data,
  output logic                       m_hdr_valid,
  input  logic                       m_hdr_ready,
  output logic [31:0]                drop_count
);

  action_t                    act_in;
  logic                       unused_rsvd;
  logic                       st1_valid;
  logic [AVST_DATA_WIDTH-1:0] st1_hdr;
  action_t                    st1_act;
  logic [7:0]                 ttl;
  logic                       ttl_expired;
  logic                       st1_drop;
  logic                       st1_emit;
  logic                       st2_can_load;
  logic                       st1_can_load;
  logic                       accept;
  logic [AVST_DATA_WIDTH-1:0] hdr_next;

  // Decode action word; reserved bits [15:5] are ignored
  always_comb begin
    act_in.set_dmac = s_act_data[ACT_SET_DMAC];
    act_in.set_smac = s_act_data[ACT_SET_SMAC];
    act_in.set_vlan = s_act_data[ACT_SET_VLAN];
    act_in.dec_ttl  = s_act_data[ACT_DEC_TTL];
    act_in.drop     = s_act_data[ACT_DROP];
    act_in.dmac     = s_act_data[ACT_DMAC_LSB +: 48];
    act_in.smac     = s_act_data[ACT_SMAC_LSB +: 48];
    act_in.vlan     = s_act_data[ACT_VLAN_LSB +: 16];
    unused_rsvd     = ^s_act_data[15:5];
  end

  assign ttl          = st1_hdr[TTL_OFFSET +: 8];
  assign ttl_expired  = st1_act.dec_ttl && (ttl < 8'd2);
  assign st1_drop     = st1_valid && (st1_act.drop || ttl_expired);
  assign st2_can_load = !m_hdr_valid || m_hdr_ready;
  assign st1_emit     = st1_valid && !st1_drop && st2_can_load;
  // A dropping st1 entry retires without an output slot, so it also frees st1
  assign st1_can_load = !st1_valid || st2_can_load || st1_drop;
  assign accept       = s_hdr_valid && s_act_valid && st1_can_load && rst_n;
  assign s_hdr_ready  = accept;
  assign s_act_ready  = accept;

`ifdef ACTION_SET_JOIN_CSUM_EN
  logic [15:0] csum_new;

  ipv4_csum_adjust u_csum (
    .old16    ({ttl, st1_hdr[TTL_OFFSET+8 +: 8]}),
    .new16    ({ttl - 8'd1, st1_hdr[TTL_OFFSET+8 +: 8]}),
    .csum_in  (st1_hdr[CSUM_OFFSET +: 16]),
    .csum_out (csum_new)
  );
`endif

  // Field edits applied to the st1 header
  always_comb begin
    hdr_next = st1_hdr;
    if (st1_act.set_dmac) hdr_next[DMAC_OFFSET +: 48] = st1_act.dmac;
    if (st1_act.set_smac) hdr_next[SMAC_OFFSET +: 48] = st1_act.smac;
    if (st1_act.set_vlan) hdr_next[VLAN_OFFSET +: 16] = st1_act.vlan;
    if (st1_act.dec_ttl && !ttl_expired) begin
      hdr_next[TTL_OFFSET +: 8] = ttl - 8'd1;
`ifdef ACTION_SET_JOIN_CSUM_EN
      hdr_next[CSUM_OFFSET +: 16] = csum_new;
`else
      hdr_next[CSUM_OFFSET +: 16] = st1_hdr[CSUM_OFFSET +: 16];
`endif
    end
  end

  // Stage 1: capture joined header/action, empty on retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_valid <= 1'b0;
      st1_hdr   <= '0;
      st1_act   <= '0;
    end else if (accept) begin
      st1_valid <= 1'b1;
      st1_hdr   <= s_hdr_data;
      st1_act   <= act_in;
    end else if (st1_drop || st1_emit) begin
      st1_valid <= 1'b0;
    end
  end

  // Stage 2: output register, held while valid and not ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hdr_valid <= 1'b0;
      m_hdr_data  <= '0;
    end else if (st1_emit) begin
      m_hdr_valid <= 1'b1;
      m_hdr_data  <= hdr_next;
    end else if (m_hdr_ready) begin
      m_hdr_valid <= 1'b0;
    end
  end

  // Saturating count of retired drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (st1_drop && (drop_count != '1)) begin
      drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_action_set_join.sv
// Scoreboard bench for action_set_join: expected headers are pushed on
// accept from a reference model and compared as outputs are taken.
module tb_action_set_join;

  localparam int W = 600;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   s_hdr_data;
  logic           s_hdr_valid;
  logic           s_hdr_ready;
  logic [127:0]   s_act_data;
  logic           s_act_valid;
  logic           s_act_ready;
  logic [W-1:0]   m_hdr_data;
  logic           m_hdr_valid;
  logic           m_hdr_ready = 1'b1;
  logic [31:0]    drop_count;

  int checks = 0;
  int errors = 0;
  int exp_drops = 0;
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: held low
  logic [W-1:0] sb[$];

  action_set_join dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_hdr_data  (s_hdr_data),
    .s_hdr_valid (s_hdr_valid),
    .s_hdr_ready (s_hdr_ready),
    .s_act_data  (s_act_data),
    .s_act_valid (s_act_valid),
    .s_act_ready (s_act_ready),
    .m_hdr_data  (m_hdr_data),
    .m_hdr_valid (m_hdr_valid),
    .m_hdr_ready (m_hdr_ready),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference edit model, default offsets written out literally
  function automatic logic [W-1:0] model(input logic [W-1:0] h, input logic [127:0] a,
                                         output bit drop);
    logic [W-1:0] r;
    logic [7:0]   t;
    logic [31:0]  s;
    r = h;
    drop = a[4];
    t = h[215:208];
    if (a[0]) r[47:0]    = a[63:16];
    if (a[1]) r[95:48]   = a[111:64];
    if (a[2]) r[127:112] = a[127:112];
    if (a[3]) begin
      if (t <= 8'd1) drop = 1'b1;
      else begin
        r[215:208] = t - 8'd1;
`ifdef ACTION_SET_JOIN_CSUM_EN
        s = {16'd0, ~h[239:224]} + {16'd0, ~{t, h[223:216]}} + {16'd0, t - 8'd1, h[223:216]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        r[239:224] = ~s[15:0];
`else
        s = 32'd0;
`endif
      end
    end
    return r;
  endfunction

  // Downstream ready pattern, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_hdr_ready = 1'b1;
      1:       m_hdr_ready = ~m_hdr_ready;
      default: m_hdr_ready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop on transfer, stability while stalled
  logic         stall_q = 1'b0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", m_hdr_valid, 1);
        check("hold_data", m_hdr_data, held);
      end
      if (m_hdr_valid && m_hdr_ready) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else check("out_data", m_hdr_data, sb.pop_front());
      end
      stall_q = m_hdr_valid && !m_hdr_ready;
      held = m_hdr_data;
    end
  end

  task automatic send(input logic [W-1:0] h, input logic [127:0] a, output int waits);
    logic [W-1:0] e;
    bit d;
    bit ok;
    ok = 1'b1;
    waits = 0;
    @(negedge clk);
    s_hdr_data = h; s_act_data = a; s_hdr_valid = 1'b1; s_act_valid = 1'b1;
    while (1) begin
      #4;
      if (s_hdr_ready && s_act_ready) break;
      waits++;
      if (waits > 200) begin check("send_timeout", 1, 0); ok = 1'b0; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      e = model(h, a, d);
      if (d) exp_drops++;
      else sb.push_back(e);
      #1;
    end
    s_hdr_valid = 1'b0; s_act_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_hdr();
    logic [W-1:0] h;
    for (int unsigned i = 0; i < W; i += 32) h[i +: 32] = $urandom();
    return h;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] h;
    logic [127:0] a;
    int w;

    // Reset state, with both valids high to show readys stay low
    rst_n = 1'b0;
    s_hdr_data = '0; s_act_data = '0; s_hdr_valid = 1'b1; s_act_valid = 1'b1;
    #12;
    check("rst_m_valid", m_hdr_valid, 0);
    check("rst_m_data", m_hdr_data, 0);
    check("rst_drops", drop_count, 0);
    check("rst_hdr_ready", s_hdr_ready, 0);
    check("rst_act_ready", s_act_ready, 0);
    s_hdr_valid = 1'b0; s_act_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: set DMAC on zero header, two-cycle latency
    a = '0; a[0] = 1'b1; a[63:16] = 48'h0A0B0C0D0E0F;
    send('0, a, w);
    @(negedge clk); check("lat_cycle1", m_hdr_valid, 0);
    @(negedge clk); check("lat_cycle2", m_hdr_valid, 1);
    drain();

    // 2: lone header waits; join happens as soon as the action appears
    h = rand_hdr(); a = '0; a[2] = 1'b1; a[127:112] = 16'h8123;
    @(negedge clk); s_hdr_data = h; s_hdr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #4; check("lone_hdr_ready", s_hdr_ready, 0);
      @(negedge clk);
    end
    check("lone_m_valid", m_hdr_valid, 0);
    send(h, a, w);
    check("join_waits", w, 0);
    drain();

    // 3: eight back-to-back random pairs with toggling ready
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      h = rand_hdr();
      if (h[215:208] < 8'd2) h[215:208] = 8'h80;
      a = {$urandom(), $urandom(), $urandom(), $urandom()};
      a[4] = 1'b0;
      send(h, a, w);
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // 4: TTL expiry drop followed by normal decrement
    h = rand_hdr(); h[215:208] = 8'h01; a = '0; a[3] = 1'b1;
    send(h, a, w);
    h = rand_hdr(); h[215:208] = 8'h40;
    send(h, a, w);
    check("ttl_no_bubble", w, 0);
    drain();
    check("drops_ttl", drop_count, exp_drops);
    check("drops_ttl_one", drop_count, 1);

    // 5: checksum update (or passthrough) on TTL decrement
    h = '0; h[215:208] = 8'h40; h[223:216] = 8'h06; h[239:224] = 16'hB1E6;
    send(h, a, w);
    drain();

    // Drop retires under full backpressure and frees st1 for a new accept
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    send(rand_hdr(), '0, w);
    a = '0; a[4] = 1'b1;
    send(rand_hdr(), a, w);
    check("drop_accept_waits", w, 0);
    send(rand_hdr(), '0, w);
    check("after_drop_waits", w, 0);
    repeat (3) @(negedge clk);
    check("drops_stalled", drop_count, exp_drops);
    check("stalled_m_valid", m_hdr_valid, 1);
    rdy_mode = 0;
    drain();

    // 6: reset with both stages full discards in-flight headers
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    send(rand_hdr(), '0, w);
    send(rand_hdr(), '0, w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid", m_hdr_valid, 0);
    check("mid_rst_drops", drop_count, 0);
    check("mid_rst_m_data", m_hdr_data, 0);
    sb.delete();
    exp_drops = 0;
    rdy_mode = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_m_valid", m_hdr_valid, 0);
    h = rand_hdr(); a = '0; a[1] = 1'b1; a[111:64] = 48'h112233445566;
    send(h, a, w);
    check("post_rst_waits", w, 0);
    drain();
    check("final_drops", drop_count, exp_drops);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
